// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB transmit sequencer.
package usb_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        DATA = 2'd2,
        EOP  = 2'd3
    } tx_state_t;

    localparam logic [7:0] SYNC_PATTERN   = 8'h80;
    localparam int         EOP_SE0_BITS   = 2;
    localparam int         EOP_TOTAL_BITS = 3;

endpackage

// File: rtl/usb_tx_bit_timer.sv
// Bit-period counter: counts 1..CLKS_PER_BIT while enabled, strobes on the last count.
module usb_tx_bit_timer #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic strobe
);
    localparam int              CW   = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0]   LAST = CW'(CLKS_PER_BIT);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          roll;

    // Count 0 only ever appears while cleared, so the strobe cannot fire when idle.
    assign roll   = (cnt_q == LAST);
    assign strobe = roll;

    // Next count: clear wins, otherwise wrap from LAST straight back to 1.
    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = roll ? CW'(1) : cnt_q + CW'(1);
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/usb_tx_sequencer.sv
// USB TX packet sequencer: SYNC / DATA / EOP framing, byte prefetch and stuff slots.
module usb_tx_sequencer
    import usb_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 8,
    parameter int LEN_W        = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] pkt_len,
    output logic             byte_req,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    input  logic             stuff_hold,
    output logic             bit_strobe,
    output logic             tx_bit,
    output logic             eop,
    output logic [1:0]       tx_state,
    output logic             busy,
    output logic             done,
    output logic             underrun
);
    tx_state_t        state_q, state_d;
    logic [2:0]       bit_idx_q, bit_idx_d;   // bit within byte, or EOP period index
    logic [7:0]       sh_q, sh_d;             // serializer, bit 0 is on the wire
    logic [7:0]       buf_q, buf_d;           // one-byte prefetch buffer
    logic             buf_full_q, buf_full_d;
    logic [LEN_W-1:0] fetch_q, fetch_d;       // bytes still to pull from the TX buffer
    logic [LEN_W-1:0] load_q, load_d;         // bytes still to load into the serializer
    logic             stuff_q, stuff_d;       // current bit period is a stuff slot
    logic             done_q, done_d;
    logic             underrun_c;
    logic             xfer, buf_avail;
    logic [7:0]       buf_byte;

    // The timer free-runs through a packet and is cleared whenever the FSM is (or returns to) IDLE.
    usb_tx_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .en     ((state_q != IDLE) || start),
        .clr    (state_d == IDLE),
        .strobe (bit_strobe)
    );

    assign byte_req  = !buf_full_q && (fetch_q != '0) && ((state_q == SYNC) || (state_q == DATA));
    assign xfer      = byte_req && byte_valid;
    // A byte arriving in the deadline cycle bypasses the buffer straight into the serializer.
    assign buf_avail = buf_full_q || xfer;
    assign buf_byte  = buf_full_q ? buf_q : byte_data;

    // Next-state logic: packet framing, prefetch bookkeeping and byte boundaries.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        sh_d       = sh_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        fetch_d    = fetch_q;
        load_d     = load_q;
        stuff_d    = stuff_q;
        done_d     = 1'b0;
        underrun_c = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = SYNC;
                    bit_idx_d  = '0;
                    sh_d       = SYNC_PATTERN;
                    buf_full_d = 1'b0;
                    fetch_d    = pkt_len;
                    load_d     = pkt_len;
                    stuff_d    = 1'b0;
                end
            end
            SYNC, DATA: begin
                if (xfer) begin
                    buf_d      = byte_data;
                    buf_full_d = 1'b1;
                    fetch_d    = fetch_q - LEN_W'(1);
                end
                if (bit_strobe) begin
                    if ((state_q == DATA) && stuff_hold) begin
                        // Freeze index and serializer; the boundary moves out one period.
                        stuff_d = 1'b1;
                    end else begin
                        stuff_d = 1'b0;
                        if (bit_idx_q == 3'd7) begin
                            bit_idx_d = '0;
                            if (load_q == '0) begin
                                state_d = EOP;
                            end else if (buf_avail) begin
                                state_d    = DATA;
                                sh_d       = buf_byte;
                                load_d     = load_q - LEN_W'(1);
                                buf_full_d = 1'b0;
                            end else begin
                                underrun_c = 1'b1;
                                state_d    = EOP;
                            end
                        end else begin
                            bit_idx_d = bit_idx_q + 3'd1;
                            sh_d      = sh_q >> 1;
                        end
                    end
                end
            end
            EOP: begin
                if (bit_strobe) begin
                    if (bit_idx_q == 3'(EOP_TOTAL_BITS - 1)) begin
                        state_d   = IDLE;
                        bit_idx_d = '0;
                        done_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any packet in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bit_idx_q  <= '0;
            sh_q       <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            fetch_q    <= '0;
            load_q     <= '0;
            stuff_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            sh_q       <= sh_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            fetch_q    <= fetch_d;
            load_q     <= load_d;
            stuff_q    <= stuff_d;
            done_q     <= done_d;
        end
    end

    // Line outputs come only from registers, so they change only after a strobe.
    always_comb begin
        tx_bit = 1'b0;
        unique case (state_q)
            SYNC, DATA: tx_bit = !stuff_q && sh_q[0];
            EOP:        tx_bit = (bit_idx_q == 3'(EOP_SE0_BITS));
            default:    tx_bit = 1'b0;
        endcase
    end

    assign eop      = (state_q == EOP) && (bit_idx_q < 3'(EOP_SE0_BITS));
    assign tx_state = state_q;
    assign busy     = (state_q != IDLE);
    assign done     = done_q;
    assign underrun = underrun_c;

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Scoreboard bench for usb_tx_sequencer: a packet-level model fills an expected-bit queue,
// a monitor pops one entry per bit_strobe and checks timing, framing, done and idle state.
module tb_usb_tx_sequencer;
    localparam int CPB = 4;
    localparam int LW  = 7;

    typedef struct packed {
        logic b;   // NRZ bit of the period
        logic e;   // SE0 period
        logic u;   // underrun expected at the strobe ending this period
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b1;
    logic [LW-1:0] pkt_len = '0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          stuff_hold = 1'b0;
    logic          byte_req, bit_strobe, tx_bit, eop, busy, done, underrun;
    logic [1:0]    tx_state;

    usb_tx_sequencer #(.CLKS_PER_BIT(CPB), .LEN_W(LW)) dut (
        .clk(clk), .rst(rst), .start(start), .pkt_len(pkt_len),
        .byte_req(byte_req), .byte_valid(byte_valid), .byte_data(byte_data),
        .stuff_hold(stuff_hold), .bit_strobe(bit_strobe), .tx_bit(tx_bit),
        .eop(eop), .tx_state(tx_state), .busy(busy), .done(done), .underrun(underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int         n_chk = 0, n_fail = 0;
    exp_t       exp_q[$];
    logic [7:0] src_q[$];
    bit         stuff_at[256];
    int         start_cyc = 0, done_rel = 0, cur_len = 0;
    int         pkt_seq = 0, done_seq = 0, abort_seq = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (rel cycle %0d)", nm, act, exp, cyc - start_cyc);
        end
    endtask

    // Monitor: per-cycle schedule checks while a packet is live, all-zero checks otherwise.
    initial begin
        int   rel;
        bit   live, in_pkt;
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) continue;
            live = (pkt_seq != done_seq) && (pkt_seq != abort_seq);
            if (!live) begin
                chk("idle_outputs", 32'({byte_req, bit_strobe, tx_bit, eop, tx_state, busy, done, underrun}), 32'd0);
                continue;
            end
            rel    = cyc - start_cyc;
            in_pkt = (rel >= 1) && (rel < done_rel);
            chk("bit_strobe", 32'(bit_strobe), 32'(in_pkt && (rel % CPB == 0)));
            chk("busy", 32'(busy), 32'(in_pkt));
            chk("done", 32'(done), 32'(rel == done_rel));
            if (in_pkt) begin
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL scoreboard_empty: got bit period at rel %0d expected none", rel);
                end else begin
                    e = exp_q[0];
                    if (!e.e) chk("tx_bit", 32'(tx_bit), 32'(e.b));
                    chk("eop", 32'(eop), 32'(e.e));
                    chk("underrun", 32'(underrun), 32'(bit_strobe && e.u));
                    if (bit_strobe) void'(exp_q.pop_front());
                end
            end else begin
                chk("underrun_edge", 32'(underrun), 32'd0);
            end
            if (rel == 1) begin
                chk("byte_req_sync", 32'(byte_req), 32'(cur_len > 0));
                chk("state_sync", 32'(tx_state), 32'd1);
            end
            if (rel == done_rel) begin
                chk("state_at_done", 32'(tx_state), 32'd0);
                done_seq = pkt_seq;
            end
        end
    end

    // Byte source and stuff requester, driven just after each rising edge.
    initial begin
        bit took;
        int dly = 0;
        int r;
        forever begin
            @(negedge clk);
            took = byte_req && byte_valid && !rst;
            @(posedge clk);
            #1;
            if (took && src_q.size() > 0) begin
                void'(src_q.pop_front());
                dly = $urandom_range(0, 6);
            end
            if (src_q.size() > 0 && dly == 0) begin
                byte_valid = 1'b1;
                byte_data  = src_q[0];
            end else begin
                byte_valid = 1'b0;
                byte_data  = 8'($urandom);
                if (dly > 0) dly--;
            end
            r = cyc - start_cyc;
            stuff_hold = (pkt_seq != abort_seq) && (r > 0) && (r % CPB == 0) &&
                         (r / CPB < 256) && stuff_at[r / CPB];
        end
    end

    // Issue one packet. withhold: index of the first byte never offered.
    // stuff_mode 0 none, 1 random, 2 one slot after strobe 11. busy_rel/rst_rel: extra start / reset at that rel cycle.
    task automatic run_pkt(input int len, input int fixed, input int withhold,
                           input int stuff_mode, input int busy_rel, input int rst_rel);
        logic [7:0] bytes[$];
        logic [7:0] tmp;
        bit         dat[$];
        exp_t       lst[$];
        int         nsent, g, guard;
        for (int i = 0; i < len; i++) bytes.push_back(fixed >= 0 ? 8'(fixed) : 8'($urandom));
        for (int i = 0; i < 256; i++) stuff_at[i] = (stuff_mode == 1) && ($urandom_range(0, 5) == 0);
        if (stuff_mode == 2) stuff_at[11] = 1'b1;
        nsent = (withhold < len) ? withhold : len;
        // Reference: SYNC 0x80 LSB first, payload LSB first with a 0 slot after each stuffed DATA strobe.
        for (int b = 0; b < 8; b++) lst.push_back('{b: (b == 7), e: 1'b0, u: 1'b0});
        for (int i = 0; i < nsent; i++) begin
            tmp = bytes[i];
            for (int b = 0; b < 8; b++) begin
                dat.push_back(tmp[b]);
                g = 8 + dat.size();
                while (g < 256 && stuff_at[g]) begin
                    dat.push_back(1'b0);
                    g = 8 + dat.size();
                end
            end
        end
        foreach (dat[i]) lst.push_back('{b: dat[i], e: 1'b0, u: 1'b0});
        if (nsent < len) lst[lst.size() - 1].u = 1'b1;
        lst.push_back('{b: 1'b0, e: 1'b1, u: 1'b0});
        lst.push_back('{b: 1'b0, e: 1'b1, u: 1'b0});
        lst.push_back('{b: 1'b1, e: 1'b0, u: 1'b0});
        done_rel = (8 + dat.size() + 3) * CPB + 1;
        foreach (lst[i]) exp_q.push_back(lst[i]);
        for (int i = 0; i < nsent; i++) src_q.push_back(bytes[i]);

        @(posedge clk); #1;
        start = 1'b1; pkt_len = LW'(len); cur_len = len; start_cyc = cyc; pkt_seq++;
        @(posedge clk); #1;
        start = 1'b0; pkt_len = LW'($urandom);

        if (rst_rel > 0) begin
            repeat (rst_rel - 1) @(posedge clk);
            #1;
            rst = 1'b1; abort_seq = pkt_seq;
            exp_q.delete(); src_q.delete();
            for (int i = 0; i < 256; i++) stuff_at[i] = 1'b0;
            @(posedge clk); #1;
            rst = 1'b0;
            return;
        end
        if (busy_rel > 0) begin
            repeat (busy_rel - 1) @(posedge clk);
            #1;
            start = 1'b1; pkt_len = LW'($urandom_range(1, 5));
            @(posedge clk); #1;
            start = 1'b0;
        end
        guard = 0;
        while (pkt_seq != done_seq && guard < done_rel + 40) begin
            @(posedge clk); #1;
            guard++;
        end
        if (pkt_seq != done_seq) begin
            n_chk++; n_fail++;
            $display("FAIL done_timeout: got no done within %0d cycles expected done at rel %0d", guard, done_rel);
            rst = 1'b1; abort_seq = pkt_seq; exp_q.delete();
            @(posedge clk); #1;
            rst = 1'b0;
        end else begin
            chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        end
        src_q.delete();
        repeat ($urandom_range(0, 3)) @(posedge clk);
    endtask

    initial begin
        int len, wh;
        // Reset for two cycles with a start pending; start must not take.
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        repeat (4) @(posedge clk);

        run_pkt(1, 8'hA5, 99, 0, 0, 0);          // single byte, done at 77
        run_pkt(1, 8'hA5, 99, 2, 0, 0);          // one stuff slot, done at 81
        run_pkt(2, -1, 1, 0, 0, 0);              // second byte missing: underrun at 64, done at 77
        run_pkt(0, -1, 99, 0, 44, 0);            // empty packet, start in final EOP strobe cycle
        run_pkt(3, -1, 99, 1, 20, 0);            // start while busy is ignored
        run_pkt(1, 8'hA5, 99, 0, 0, 40);         // reset mid-DATA
        repeat (3) @(posedge clk);
        run_pkt(1, 8'hA5, 99, 0, 0, 0);          // normal packet after reset
        run_pkt(3, -1, 0, 1, 0, 0);              // first byte missing: underrun at end of SYNC

        for (int k = 0; k < 14; k++) begin
            len = $urandom_range(0, 4);
            wh  = (len > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, len - 1) : 99;
            run_pkt(len, -1, wh, $urandom_range(0, 1), ($urandom_range(0, 2) == 0) ? $urandom_range(2, 40) : 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/usb_tx_sequencer.md
# usb_tx_sequencer

Packet-level controller for the USB transmit path. It sequences bit timing and produces SYNC, DATA and EOP phases. It fetches payload bytes from the TX buffer through a request/valid handshake and emits one NRZ bit per bit period to the downstream NRZI encoder. It also honours bit-stuff slots requested by the stuffer. It owns the bit-period counter and the bit and byte counters that schedule the serializer.

## Interface

- CLKS_PER_BIT, 8, clock cycles per USB bit period (≥2)
- LEN_W, 7, width of the byte-count field
- clk  in  1  system clock
- rst  in  1  reset; **one clock; reset is synchronous and active-high**
- start  in  1  packet request; accepted only in IDLE
- pkt_len  in  LEN_W  payload bytes including PID; sampled when start is accepted
- byte_req  out  1  prefetch request to the TX buffer
- byte_valid  in  1  byte_data valid; a transfer occurs when byte_req && byte_valid
- byte_data  in  8  payload byte, LSB transmitted first
- stuff_hold  in  1  stuffer requests a stuff slot; sampled on bit_strobe
- bit_strobe  out  1  one-cycle pulse in the last cycle of every bit period
- tx_bit  out  1  current NRZ bit; held for the whole bit period
- eop  out  1  high during the SE0 bit periods of EOP
- tx_state  out  2  current FSM state
- busy  out  1  high whenever tx_state != IDLE
- done  out  1  one-cycle pulse when the packet completes
- underrun  out  1  one-cycle pulse when a payload byte is missing at its deadline

## Operation

- FSM states: IDLE → SYNC → DATA → EOP → IDLE.
  - IDLE: all outputs 0 and the period counter is held cleared.
  - start && IDLE: latch pkt_len into the remaining count and enter SYNC. In any other state, start is ignored.
- SYNC: 8 bits of pattern 0x80, sent LSB first (0,0,0,0,0,0,0,1). stuff_hold is ignored.
  - After the 8th strobe: go to DATA if pkt_len > 0, otherwise go to EOP.
- DATA: shift out the current byte LSB first, 8 bits per byte.
  - A 1-byte prefetch buffer holds the next byte. byte_req = buffer empty && bytes-to-fetch > 0 && state ∈ {SYNC, DATA}. byte_req is asserted from the first cycle of SYNC.
  - At the strobe ending bit 7 (or ending SYNC):
    - If bytes remain and the buffer is full: load the shift register, decrement the count and empty the buffer.
    - If bytes remain and the buffer is empty: pulse underrun and go to EOP.
    - If no bytes remain: go to EOP.
- Stuff slot: stuff_hold high on a DATA strobe makes the next bit period a stuff slot.
  - tx_bit = 0 for that slot.
  - The bit index and shift register are frozen.
  - Byte boundaries are deferred by one bit period.
  - stuff_hold is ignored outside DATA.
- EOP: 2 bit periods with eop = 1 (SE0), then 1 bit period with eop = 0 and tx_bit = 1 (J).
  - After the 3rd strobe: pulse done and return to IDLE.
- rst has priority over all events. The cycle after rst is asserted: IDLE, all outputs 0, buffer emptied, counters cleared, any in-flight packet discarded.
- start and the final EOP strobe in the same cycle: start is ignored, because the FSM is not yet in IDLE.

## Timing

- Cycle 0 is the cycle in which start is sampled high in IDLE. The FSM is in SYNC from cycle 1.
- The n-th bit_strobe occurs in cycle n·CLKS_PER_BIT.
- tx_bit, eop and tx_state update in the cycle after each strobe, so each bit is stable for exactly CLKS_PER_BIT cycles.
- done occurs in cycle CLKS_PER_BIT·(8 + 8·pkt_len + stuff_slots + 3) + 1 and coincides with tx_state = IDLE.
- Prefetch deadline: the byte transfer must complete no later than the cycle of the strobe that ends the current byte's bit 7. A transfer in that same cycle is accepted.
- The period counter runs 1..CLKS_PER_BIT and wraps with no idle cycle. It never advances in IDLE.
- Reset values: byte_req, bit_strobe, tx_bit, eop, busy, done and underrun are 0; tx_state = IDLE (2'd0).

## Structure

- Package usb_tx_pkg:
  - tx_state_t enum: IDLE = 0, SYNC = 1, DATA = 2, EOP = 3
  - SYNC_PATTERN = 8'h80
  - EOP_SE0_BITS = 2
  - EOP_TOTAL_BITS = 3
- Sub-module usb_tx_bit_timer: parameterized period counter with enable, clear and rollover flag, producing bit_strobe.
- The FSM, bit index, byte count, prefetch buffer and shift register live in the top module.

## Test plan

All scenarios use CLKS_PER_BIT = 4.

- Reset: rst high for 2 cycles → all outputs 0, tx_state = 0. A start during rst is ignored.
- Single byte: start with pkt_len = 1, byte 0xA5 valid immediately.
  - bit_strobe every 4 cycles.
  - tx_bit sequence 0000_0001 then 1010_0101.
  - eop high for strobes 17–18.
  - done in cycle 77.
- Stuff slot: same as the single-byte case, with stuff_hold = 1 on the 3rd DATA strobe → one extra 0 slot and data order preserved; done in cycle 81.
- Underrun: pkt_len = 2, second byte_valid withheld.
  - underrun pulses at the strobe in cycle 64.
  - EOP follows, done in cycle 77.
  - byte_req drops in IDLE.
- Empty and busy start: pkt_len = 0 → SYNC then EOP, done in cycle 45. A second start while busy is ignored, with no extra done.
- Reset mid-DATA: rst in cycle 40 → IDLE with outputs 0 from cycle 41. A new start afterwards gives a normal single-byte packet with done 77 cycles after that start.
